// File: rtl/mp_add_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// Holds the FSM state encoding, the limb width and the len-port width helper.
package mp_add_pkg;

    localparam int LIMB_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Width needed to encode limb counts 0..max_limbs inclusive
    function automatic int calc_len_w(input int max_limbs);
        return $clog2(max_limbs + 1);
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Control, limb-stream and status bundle of mp_add_seq.
// master = operand streamer / writeback side, slave = the sequencer.
interface mp_add_seq_if
    import mp_add_pkg::*;
#(
    parameter int MAX_LIMBS = 4,
    parameter int LEN_W     = calc_len_w(MAX_LIMBS)
) ();

    logic                start;
    logic                sub;
    logic [LEN_W-1:0]    len;
    logic                in_valid;
    logic                in_ready;
    logic [LIMB_W-1:0]   a_word;
    logic [LIMB_W-1:0]   b_word;
    logic                out_valid;
    logic                out_ready;
    logic [LIMB_W-1:0]   s_word;
    logic                s_last;
    logic                busy;
    logic                done;
    logic                carry_out;
    logic                ovf;

    modport master (
        output start, sub, len, in_valid, a_word, b_word, out_ready,
        input  in_ready, out_valid, s_word, s_last, busy, done, carry_out, ovf
    );

    modport slave (
        input  start, sub, len, in_valid, a_word, b_word, out_ready,
        output in_ready, out_valid, s_word, s_last, busy, done, carry_out, ovf
    );

endinterface

// File: rtl/mp_add_seq_cla.sv
// CLA_Add64: combinational 64-bit carry-lookahead adder built from sixteen
// 4-bit lookahead groups whose group generate/propagate chain the carry.
module CLA_Add64 (
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic        cIn,
    output logic [63:0] sum,
    output logic        cOut
);

    logic [63:0] w_g;
    logic [63:0] w_p;
    logic [16:0] w_gc;

    assign w_g     = x & y;
    assign w_p     = x ^ y;
    assign w_gc[0] = cIn;
    assign cOut    = w_gc[16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_grp
            logic [3:0] w_gg;
            logic [3:0] w_pp;
            logic [3:0] w_bc;
            logic       w_grp_g;
            logic       w_grp_p;

            assign w_gg = w_g[4*gi +: 4];
            assign w_pp = w_p[4*gi +: 4];

            // In-group carries expanded so none ripples through a neighbour bit
            assign w_bc[0] = w_gc[gi];
            assign w_bc[1] = w_gg[0] | (w_pp[0] & w_gc[gi]);
            assign w_bc[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (&w_pp[1:0] & w_gc[gi]);
            assign w_bc[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (&w_pp[2:1] & w_gg[0])
                           | (&w_pp[2:0] & w_gc[gi]);

            assign w_grp_g = w_gg[3] | (w_pp[3] & w_gg[2]) | (&w_pp[3:2] & w_gg[1])
                           | (&w_pp[3:1] & w_gg[0]);
            assign w_grp_p = &w_pp;

            assign w_gc[gi+1]      = w_grp_g | (w_grp_p & w_gc[gi]);
            assign sum[4*gi +: 4]  = w_pp ^ w_bc;
        end
    endgenerate

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams limbs LS-first through one
// CLA_Add64 with a registered carry. Optional MP_ADD_SEQ_OVF_EN adds signed overflow.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int MAX_LIMBS = 4,
    parameter int LEN_W     = calc_len_w(MAX_LIMBS)
) (
    input  logic          clk,
    input  logic          rst_n,
    mp_add_seq_if.slave   bus
);

    state_t              r_state;
    logic                r_sub;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_count;
    logic                r_carry;
    logic                r_out_valid;
    logic [LIMB_W-1:0]   r_s_word;
    logic                r_s_last;
    logic                r_busy;
    logic                r_done;
    logic                r_carry_out;

    logic [LIMB_W-1:0]   w_y;
    logic [LIMB_W-1:0]   w_sum;
    logic                w_cout;
    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_is_last;
    logic                w_len_ok;

    CLA_Add64 u_cla (
        .x    (bus.a_word),
        .y    (w_y),
        .cIn  (r_carry),
        .sum  (w_sum),
        .cOut (w_cout)
    );

    // Subtraction as A + ~B + 1: the +1 comes from the carry seeded with sub
    assign w_y        = r_sub ? ~bus.b_word : bus.b_word;
    assign w_in_ready = (r_state == RUN) && (!r_out_valid || bus.out_ready);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_is_last  = (r_count == r_len - LEN_W'(1));
    assign w_len_ok   = (bus.len != '0) && (bus.len <= LEN_W'(MAX_LIMBS));

`ifdef MP_ADD_SEQ_OVF_EN
    logic r_ovf;
    logic r_ovf_pend;
    logic w_ovf;

    assign w_ovf = (bus.a_word[LIMB_W-1] == w_y[LIMB_W-1]) &&
                   (w_sum[LIMB_W-1] != bus.a_word[LIMB_W-1]);
    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sub       <= 1'b0;
            r_len       <= '0;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_s_word    <= '0;
            r_s_last    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_carry_out <= 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
            r_ovf       <= 1'b0;
            r_ovf_pend  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && w_len_ok) begin
                        r_sub       <= bus.sub;
                        r_len       <= bus.len;
                        r_carry     <= bus.sub;
                        r_count     <= '0;
                        r_busy      <= 1'b1;
                        r_carry_out <= 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
                        r_ovf       <= 1'b0;
`endif
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_in_fire) begin
                        r_s_word    <= w_sum;
                        r_out_valid <= 1'b1;
                        r_carry     <= w_cout;
                        r_count     <= r_count + LEN_W'(1);
                        r_s_last    <= w_is_last;
                        if (w_is_last) begin
                            r_state <= FLUSH;
`ifdef MP_ADD_SEQ_OVF_EN
                            r_ovf_pend <= w_ovf;
`endif
                        end
                    end else if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (r_out_valid && bus.out_ready && r_s_last) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_carry_out <= r_carry;
                        r_busy      <= 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
                        r_ovf       <= r_ovf_pend;
`endif
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s_word    = r_s_word;
    assign bus.s_last    = r_s_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.carry_out = r_carry_out;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: directed cases plus randomized operations
// checked against a big-integer arithmetic model.
module tb_mp_add_seq;

    localparam int ML = 4;
    localparam int LW = $clog2(ML + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mp_add_seq_if #(.MAX_LIMBS(ML)) bus ();

    mp_add_seq #(.MAX_LIMBS(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 3))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // bp: 0 = always ready, 1 = random out_ready, 2 = 3-cycle stall after first output
    task automatic run_op(input int len, input logic sub, input logic [255:0] a_in,
                          input logic [255:0] b_in, input int bp, input bit gaps,
                          input bit hold_start);
        logic [319:0]        a, b, res;
        logic signed [319:0] sa, sb, sr, lim;
        logic                exp_c, exp_o;
        logic [63:0]         held_w;
        int n, sent, got, cyc, stall_left, last_fire;
        bit fin, held;

        n = len * 64; sent = 0; got = 0; cyc = 0; stall_left = 3; last_fire = -10;
        fin = 1'b0; held = 1'b0; held_w = '0;
        a = '0; b = '0;
        for (int i = 0; i < len; i++) begin
            a[64*i +: 64] = a_in[64*i +: 64];
            b[64*i +: 64] = b_in[64*i +: 64];
        end
        if (sub) begin
            res   = a - b;
            exp_c = (a >= b);
        end else begin
            res   = a + b;
            exp_c = res[n];
        end
        lim = 320'sd1 <<< (n - 1);
        sa  = $signed(a);
        sb  = $signed(b);
        if (a[n-1]) sa = sa - (lim <<< 1);
        if (b[n-1]) sb = sb - (lim <<< 1);
        sr    = sub ? (sa - sb) : (sa + sb);
        exp_o = (sr >= lim) || (sr < -lim);
`ifndef MP_ADD_SEQ_OVF_EN
        exp_o = 1'b0;
`endif

        @(negedge clk);
        bus.start = 1'b1; bus.sub = sub; bus.len = LW'(len);
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        chk("busy_after_start", {63'b0, bus.busy}, 64'd1);
        chk("carry_cleared", {63'b0, bus.carry_out}, 64'd0);

        while (!fin && cyc < 400) begin
            bus.in_valid = (sent < len) && (!gaps || $urandom_range(0, 3) != 0);
            bus.a_word   = a[64*sent +: 64];
            bus.b_word   = b[64*sent +: 64];
            case (bp)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (got >= 1 && stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
            endcase
            if (hold_start) begin
                bus.len = LW'($urandom_range(0, 7));
                bus.sub = 1'($urandom_range(0, 1));
            end
            #1;
            if (held) chk("held_word", bus.s_word, held_w);
            if (bus.out_valid && !bus.out_ready) begin
                chk("stall_in_ready", {63'b0, bus.in_ready}, 64'd0);
                held   = 1'b1;
                held_w = bus.s_word;
            end else begin
                held = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("s_word[%0d]", got), bus.s_word, res[64*got +: 64]);
                chk($sformatf("s_last[%0d]", got), {63'b0, bus.s_last},
                    {63'b0, (got == len - 1)});
                got++;
                last_fire = cyc;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
            cyc++;
            if (bus.done) fin = 1'b1;
        end

        chk("done_seen", {63'b0, fin}, 64'd1);
        chk("limb_count", 64'(got), 64'(len));
        chk("done_latency", 64'(cyc - last_fire), 64'd1);
        chk("carry_out", {63'b0, bus.carry_out}, {63'b0, exp_c});
        chk("ovf", {63'b0, bus.ovf}, {63'b0, exp_o});
        chk("busy_clear", {63'b0, bus.busy}, 64'd0);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {63'b0, bus.done}, 64'd0);
        chk("carry_hold", {63'b0, bus.carry_out}, {63'b0, exp_c});
        $display("op len=%0d sub=%0d bp=%0d carry=%0d ovf=%0d limbs=%0d lo=%h",
                 len, sub, bp, exp_c, exp_o, got, res[63:0]);
    endtask

    task automatic illegal_start(input int len);
        @(negedge clk);
        bus.start = 1'b1; bus.len = LW'(len); bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk($sformatf("illegal_busy_len%0d", len), {63'b0, bus.busy}, 64'd0);
        chk("illegal_in_ready", {63'b0, bus.in_ready}, 64'd0);
        @(negedge clk);
        chk("illegal_done", {63'b0, bus.done}, 64'd0);
        $display("illegal start len=%0d busy=%0d", len, bus.busy);
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        bus.start = 1'b1; bus.len = LW'(4); bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.a_word = 64'hFFFF_FFFF_FFFF_FFFF; bus.b_word = 64'h1;
        @(negedge clk);
        bus.a_word = 64'h1234; bus.b_word = 64'h5678;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_s_word", bus.s_word, 64'd0);
        chk("rst_s_last", {63'b0, bus.s_last}, 64'd0);
        chk("rst_busy", {63'b0, bus.busy}, 64'd0);
        chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
        chk("rst_carry_out", {63'b0, bus.carry_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_done", {63'b0, bus.done}, 64'd0);
        chk("rst_idle", {63'b0, bus.busy}, 64'd0);
        $display("reset mid-op busy=%0d out_valid=%0d", bus.busy, bus.out_valid);
    endtask

    initial begin
        logic [255:0] ra, rb;
        bus.start = 1'b0; bus.sub = 1'b0; bus.len = '0;
        bus.in_valid = 1'b0; bus.a_word = '0; bus.b_word = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'b0, bus.busy}, 64'd0);
        chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("reset_s_word", bus.s_word, 64'd0);
        chk("reset_done", {63'b0, bus.done}, 64'd0);
        chk("reset_ovf", {63'b0, bus.ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1, 1'b0, 256'hFFFF_FFFF_FFFF_FFFE, 256'h1, 0, 1'b0, 1'b0);
        run_op(2, 1'b0, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, {64'h0, 64'h1}, 0, 1'b0, 1'b0);
        run_op(2, 1'b0, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
               {64'h0, 64'h1}, 0, 1'b0, 1'b0);
        run_op(1, 1'b1, 256'hE, 256'h11, 0, 1'b0, 1'b0);
        run_op(1, 1'b1, 256'h11, 256'hF, 0, 1'b0, 1'b0);
        run_op(4, 1'b0, {64'h1, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000},
               {64'h3, 64'h4, 64'h1, 64'h8000_0000_0000_0000}, 2, 1'b0, 1'b0);
        illegal_start(0);
        illegal_start(5);
        run_op(3, 1'b1, {64'h0, 64'h5, 64'h9}, {64'h0, 64'h6, 64'hA}, 0, 1'b0, 1'b1);
        reset_mid_op();
        run_op(1, 1'b0, 256'h7FFF_FFFF_FFFF_FFFF, 256'h1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 4; i++) begin
                ra[64*i +: 64] = pick();
                rb[64*i +: 64] = pick();
            end
            run_op($urandom_range(1, ML), 1'($urandom_range(0, 1)), ra, rb,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around one 64-bit carry-lookahead adder (existing CLA_Add64, instantiated unchanged).
- Adds or subtracts operands of up to MAX_LIMBS 64-bit limbs, least-significant limb first, streaming limb pairs in and sum limbs out over valid/ready handshakes.
- Chains carry between limbs in a register; one limb per cycle at full throughput.
- Sits between the register-file/memory streamer and the writeback path for big-integer operations.

Parameters:
- MAX_LIMBS, 4, maximum limbs per operation (≥1).
- LEN_W, $clog2(MAX_LIMBS+1), width of the len port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- sub  in  1  0 = A+B, 1 = A−B; latched at start.
- len  in  LEN_W  limb count for this operation; latched at start.
- in_valid  in  1  a_word/b_word valid.
- in_ready  out  1  limb pair accepted when in_valid && in_ready.
- a_word  in  64  operand A limb.
- b_word  in  64  operand B limb.
- out_valid  out  1  s_word valid.
- out_ready  in  1  downstream accepts s_word.
- s_word  out  64  result limb.
- s_last  out  1  s_word is the final (most-significant) limb.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse after the last limb handshake.
- carry_out  out  1  final carry; valid from done until next start. In sub mode, 1 = no borrow.
- ovf  out  1  signed overflow of the final limb (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready, out_valid, s_last, busy, done, carry_out, ovf = 0; s_word = 0; carry reg = 0; limb counter = 0.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - in_ready = 0.
  - On start && len ≠ 0 && len ≤ MAX_LIMBS: latch sub and len; carry reg := sub; counter := 0; go to RUN; busy = 1 next cycle.
  - start with len = 0 or len > MAX_LIMBS is ignored; state stays IDLE and no output changes.
- RUN:
  - in_ready = !out_valid || out_ready (single-entry output register, registered output).
  - Adder inputs: x = a_word; y = sub ? ~b_word : b_word; cIn = carry reg.
  - On input handshake: s_word := adder sum; out_valid := 1; carry reg := adder cOut; counter += 1.
  - s_last := (counter == len−1). If this is the last limb, go to FLUSH.
  - Latency: input handshake to out_valid is 1 cycle.
  - Throughput: 1 limb/cycle with out_ready held high.
- Output register:
  - On out_valid && out_ready with no new limb loaded in the same cycle, out_valid := 0.
  - A simultaneous input and output handshake in RUN reloads the register with out_valid staying 1.
  - s_word and s_last are held stable while out_valid && !out_ready.
- FLUSH:
  - in_ready = 0.
  - When out_valid && out_ready && s_last: out_valid := 0, done := 1 for one cycle, carry_out := carry reg, busy := 0, state := IDLE.
- carry_out and ovf hold their values until the next accepted start, which clears both to 0.
- start while busy is ignored. sub and len are ignored outside IDLE.
- A reset assertion mid-operation aborts immediately to the reset values. No partial done is produced.

Optional Feature:
- Macro: MP_ADD_SEQ_OVF_EN.
- Defined: on the final limb's input handshake, compute ovf_next = (x[63] == y[63]) && (sum[63] ≠ x[63]), using the post-inversion y. The value is held internally and presented on ovf together with done, then held as for carry_out.
- Undefined: ovf is tied to 0 and no overflow logic is synthesized. The port still exists.

Decomposition:
- Package mp_add_pkg holds:
  - the state enum {IDLE, RUN, FLUSH};
  - the LIMB_W = 64 constant;
  - a function computing LEN_W.
- Sub-module: the existing CLA_Add64, one instance, purely combinational.
- The sequencer owns all registers. No further split.

Test Plan:
1. Single limb: len=1, sub=0, A=FFFFFFFFFFFFFFFE, B=0000000000000001 -> s_word=FFFFFFFFFFFFFFFF, s_last=1, carry_out=0, done pulse 1 cycle after the output handshake.
2. Carry chain: len=2, sub=0, A limbs {FFFFFFFFFFFFFFFF, 0000000000000000}, B limbs {0000000000000001, 0000000000000000} -> s limbs {0000000000000000, 0000000000000001}, carry_out=0; then A limbs {FFFF…FF, FFFF…FF} with B limbs {1, 0} -> s limbs {0, 0}, carry_out=1.
3. Subtract/borrow: len=1, sub=1, A=000000000000000E, B=0000000000000011 -> s_word=FFFFFFFFFFFFFFFD, carry_out=0; A=0x11, B=0x0F -> s_word=0000000000000002, carry_out=1.
4. Backpressure: len=4, out_ready low for 3 cycles after the first output -> in_ready=0 while out_valid && !out_ready, s_word held stable, all 4 limbs are correct and in order, and exactly one s_last.
5. Illegal and overlapping starts: start with len=0 -> busy stays 0; start asserted during RUN -> ignored, results unchanged.
6. Reset mid-op plus overflow: assert rst_n=0 after limb 2 of 4 -> all outputs 0 and state IDLE. With MP_ADD_SEQ_OVF_EN defined: len=1, A=7FFFFFFFFFFFFFFF, B=1 -> ovf=1 with done; without the macro -> ovf=0.
